// File: rtl/register_pipe.sv
`default_nettype none
// ============================================================================
// Module      : register_pipe
// Description : Elastic DEPTH-stage valid/ready register pipeline with bubble
//               collapsing, synchronous flush and stage-occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module register_pipe #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int OCC_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OCC_WIDTH-1:0]  occupancy
);

  logic [DEPTH-1:0]      r_v;
  logic [DATA_WIDTH-1:0] r_d   [DEPTH];
  logic [DEPTH:0]        w_chain;
  logic [DEPTH-1:0]      w_load;
  logic [DATA_WIDTH-1:0] w_src [DEPTH];

  // w_chain[i] is the accept term of stage i; w_chain[i+1] is its advance term.
  always_comb begin
    w_chain        = '0;
    w_chain[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_chain[i] = ~r_v[i] | w_chain[i+1];
    end
  end

  assign in_ready = w_chain[0] & ~flush;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
        assign w_src[i]  = in_data;
        assign w_load[i] = in_valid & in_ready;
      end else begin : g_body
        assign w_src[i]  = r_d[i-1];
        assign w_load[i] = r_v[i-1] & w_chain[i] & ~flush;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          r_v[i] <= 1'b0;
        end else begin
          r_v[i] <= w_load[i] | (r_v[i] & ~w_chain[i+1]);
        end
        // Data only moves on a load, so flushed or drained stages keep stale payload.
        if (w_load[i]) begin
          r_d[i] <= w_src[i];
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_WIDTH'(r_v[i]);
    end
  end

  assign out_valid = r_v[DEPTH-1] & ~flush;
  assign out_data  = r_d[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_register_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_pipe
// Description : Self-checking bench for register_pipe (DEPTH=4/W=8 and
//               DEPTH=1/W=1) against a word-position queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_pipe;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, out_ready;
  logic [7:0] in_data;

  logic       ir4, ov4;
  logic [7:0] od4;
  logic [2:0] occ4;
  logic       ir1, ov1;
  logic [0:0] od1;
  logic [0:0] occ1;

  int checks = 0;
  int errors = 0;
  int phase, D;
  bit cmp_en;

  logic       dut_ir, dut_ov;
  logic [7:0] dut_od;
  int         dut_occ;

  // Model: each queued word carries its current stage index (oldest first).
  int qpos[$];
  int qdat[$];
  int np[4];
  int rx[$];
  bit m_acc;

  always #5 clk = ~clk;

  register_pipe #(.DATA_WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .occupancy(occ4)
  );

  register_pipe #(.DATA_WIDTH(1), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data[0:0]),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(occ1)
  );

  always_comb begin
    dut_ir  = (phase != 0) ? ir1 : ir4;
    dut_ov  = (phase != 0) ? ov1 : ov4;
    dut_od  = (phase != 0) ? {7'd0, od1} : od4;
    dut_occ = (phase != 0) ? int'(occ1) : int'(occ4);
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Where every word would sit after the coming edge; D means it has left.
  function void do_plan();
    for (int k = 0; k < qpos.size(); k++) begin
      if (k == 0) begin
        if (qpos[0] == D - 1) np[0] = out_ready ? D : D - 1;
        else                  np[0] = qpos[0] + 1;
      end else begin
        np[k] = (qpos[k] + 1 < np[k-1] - 1) ? qpos[k] + 1 : np[k-1] - 1;
      end
    end
  endfunction

  function bit exp_in_ready();
    do_plan();
    if (flush) return 1'b0;
    if (qpos.size() == 0) return 1'b1;
    return np[qpos.size()-1] > 0;
  endfunction

  function bit exp_out_valid();
    if (flush || qpos.size() == 0) return 1'b0;
    return qpos[0] == D - 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      qpos.delete();
      qdat.delete();
    end else begin
      m_acc = exp_in_ready();
      for (int k = 0; k < qpos.size(); k++) qpos[k] = np[k];
      if (qpos.size() > 0 && qpos[0] == D) begin
        void'(qpos.pop_front());
        void'(qdat.pop_front());
      end
      if (in_valid && m_acc) begin
        qpos.push_back(0);
        qdat.push_back(int'(in_data & ((phase != 0) ? 8'h01 : 8'hFF)));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("out_valid", int'(dut_ov), int'(exp_out_valid()));
      chk("in_ready", int'(dut_ir), int'(exp_in_ready()));
      chk("occupancy", dut_occ, qpos.size());
      if (exp_out_valid()) chk("out_data", int'(dut_od), qdat[0]);
      if (dut_ov && out_ready) rx.push_back(int'(dut_od));
    end
  end

  task automatic cyc(input bit iv, input logic [7:0] id, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #3;
  endtask

  task automatic rand_run(input int n);
    for (int c = 0; c < n; c++) begin
      cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);
    end
  endtask

  initial begin
    int first_out;
    int tp;
    phase = 0; D = 4; cmp_en = 1'b0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;

    #12;
    chk("rst_out_valid", int'(dut_ov), 0);
    chk("rst_out_data", int'(dut_od), 0);
    chk("rst_occupancy", dut_occ, 0);
    chk("rst_in_ready", int'(dut_ir), 1);
    @(posedge clk);
    #1 in_valid = 1'b0; rst_n = 1'b1; cmp_en = 1'b1;

    for (int c = 0; c < 10; c++) begin
      cyc(0, 8'h00, 0, 0);
      chk("idle_out_valid", int'(dut_ov), 0);
    end

    // Streaming at full rate.
    first_out = -1;
    for (int c = 0; c < 24; c++) begin
      cyc(c < 16, 8'(c + 1), 1, 0);
      if (dut_ov && first_out < 0) first_out = c;
      if (c >= 4 && c < 16) begin
        chk("stream_occ", dut_occ, 4);
        chk("stream_in_ready", int'(dut_ir), 1);
      end
    end
    chk("stream_latency", first_out, 4);
    chk("stream_count", rx.size(), 16);
    for (int i = 0; i < 16 && i < rx.size(); i++) chk("stream_order", rx[i], i + 1);
    rx.delete();

    // Backpressure and bubble collapse.
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    repeat (3) cyc(0, 8'h00, 0, 0);
    chk("bp_occ2", dut_occ, 2);
    chk("bp_in_ready", int'(dut_ir), 1);
    chk("bp_head", int'(dut_od), 8'h11);
    cyc(1, 8'h33, 0, 0);
    cyc(1, 8'h44, 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk("bp_occ4", dut_occ, 4);
    chk("bp_full_in_ready", int'(dut_ir), 0);
    cyc(0, 8'h00, 1, 0);
    chk("bp_release_in_ready", int'(dut_ir), 1);
    chk("bp_release_data", int'(dut_od), 8'h11);
    repeat (6) cyc(0, 8'h00, 1, 0);
    chk("bp_count", rx.size(), 4);
    for (int i = 0; i < 4 && i < rx.size(); i++) chk("bp_order", rx[i], 8'h11 * (i + 1));
    rx.delete();

    // Flush with simultaneous input.
    cyc(1, 8'h61, 0, 0);
    cyc(1, 8'h62, 0, 0);
    cyc(1, 8'h63, 0, 0);
    repeat (2) cyc(0, 8'h00, 0, 0);
    cyc(1, 8'h55, 0, 1);
    chk("flush_in_ready", int'(dut_ir), 0);
    chk("flush_out_valid", int'(dut_ov), 0);
    chk("flush_occ_unmasked", dut_occ, 3);
    cyc(0, 8'h00, 0, 0);
    chk("flush_occ_after", dut_occ, 0);
    repeat (6) cyc(0, 8'h00, 1, 0);
    chk("flush_nothing_out", rx.size(), 0);
    cyc(1, 8'h66, 1, 0);
    repeat (6) cyc(0, 8'h00, 1, 0);
    chk("flush_next_count", rx.size(), 1);
    if (rx.size() > 0) chk("flush_next_word", rx[0], 8'h66);
    rx.delete();

    // Asynchronous reset between edges.
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h71 + i), 0, 0);
    repeat (3) cyc(0, 8'h00, 0, 0);
    chk("arst_full", dut_occ, 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(dut_ov), 0);
    chk("arst_occ", dut_occ, 0);
    chk("arst_in_ready", int'(dut_ir), 1);
    #1 rst_n = 1'b1;
    repeat (8) cyc(0, 8'h00, 1, 0);
    chk("arst_nothing_out", rx.size(), 0);

    rand_run(3000);

    // Switch to the single-stage, single-bit instance.
    @(posedge clk);
    #2 rst_n = 1'b0;
    phase = 1; D = 1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #4 rst_n = 1'b1;
    rx.delete();

    tp = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1, 8'(c), c % 2 == 1, 0);
      if (dut_occ == 1) chk("d1_in_ready_follows", int'(dut_ir), c % 2);
      if (dut_ov && out_ready) tp++;
    end
    chk("d1_throughput", tp, 10);

    rand_run(7000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_pipe.md
Name: register_pipe

Overview:
- Parametrised elastic pipeline register: DATA_WIDTH-bit payload through DEPTH register stages with valid/ready handshaking, bubble collapsing and synchronous flush.
- Replaces fixed single-bit, always-enabled registers in the tlutMul datapath.
- Lets LUT address/operand pipelines stall under downstream backpressure without data loss.
- Provides a stage-occupancy count for the control logic.

Parameters:
- DATA_WIDTH, 8, payload width in bits; must be >= 1.
- DEPTH, 4, number of register stages; must be >= 1.
- OCC_WIDTH, $clog2(DEPTH+1), width of occupancy output; derived, not overridden.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous reset, active low.
- flush  input  1  synchronous clear of all stages.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  pipe can accept in_data this cycle.
- in_data  input  DATA_WIDTH  upstream payload.
- out_valid  output  1  stage DEPTH-1 holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DATA_WIDTH  payload of stage DEPTH-1.
- occupancy  output  OCC_WIDTH  number of stages currently holding valid data (0..DEPTH).

Behaviour:
- Reset: asynchronous, active-low on rst_n.
  - All stage valid bits and data registers are cleared to 0.
  - out_valid=0, out_data=0, occupancy=0, in_ready=1 (flush low).
  - Reset mid-stream discards all contents immediately, without waiting for a clock edge.
- Stage state: stage i (0..DEPTH-1) holds v[i] and d[i]. Stage 0 is the input stage; stage DEPTH-1 drives out_valid/out_data directly, with no output logic.
- Advance terms:
  - adv[DEPTH-1] = out_ready.
  - adv[i] = acc[i+1].
- Accept term: acc[i] = !v[i] | adv[i]. This gives bubble collapsing: a stage accepts whenever it is empty, even if downstream is stalled.
- in_ready = acc[0] & !flush. This is combinational from out_ready through the chain; the path is permitted and documented for integrators.
- Per-edge update (no flush):
  - Stage 0 loads in_data when in_valid & in_ready.
  - Stage i>0 loads d[i-1] when v[i-1] & acc[i].
  - v[i] is set on load, cleared when v[i] & adv[i] and no load.
  - d[i] changes only on load; stale data is retained otherwise.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Both may occur on the same edge; a full pipe with out_ready=1 sustains one word per cycle.
- Latency: a word captured at edge t into an empty, unstalled pipe is presented on out_valid after edge t+DEPTH-1.
  - DEPTH=1: visible right after the capture edge.
- Ordering: strict FIFO; no word is dropped or duplicated under any ready pattern.
- Flush (synchronous, highest priority below reset):
  - While flush=1, in_ready=0 and out_valid=0 (masked combinationally).
  - At the edge with flush=1, all v[i] clear. d[i] is unchanged.
  - in_valid during flush is ignored; no data is captured.
  - An out_ready seen during flush does not count as a transfer.
- occupancy: combinational popcount of v[DEPTH-1:0]. It is unaffected by the flush mask until the clearing edge.
- out_data is meaningful only when out_valid=1. It holds its last loaded value otherwise.

Test Plan:
- Reset/idle: hold rst_n=0 with in_valid=1, in_data=8'hAA.
  - Required: out_valid=0, out_data=0, occupancy=0, in_ready=1.
  - After release with in_valid=0 for 10 cycles: out_valid stays 0.
- Streaming, DEPTH=4: out_ready=1, push 0x01..0x10 on consecutive cycles.
  - Required: 0x01 appears after 3 further edges, then one word per cycle in order.
  - in_ready stays 1 and occupancy stays 4 in steady state.
- Backpressure/collapse: push 0x11, 0x22 with out_ready=0, then idle 3 cycles.
  - Required: occupancy=2, words sit in stages 3 and 2, in_ready=1.
  - Fill to 4 words: in_ready=0.
  - Raise out_ready for one cycle: 0x11 leaves, in_ready=1 in the same cycle.
  - Data order 0x11, 0x22, 0x33, 0x44 preserved.
- Flush with simultaneous input: pipe holds 3 words; assert flush=1 with in_valid=1, in_data=0x55 for one cycle.
  - Required: in_ready=0 and out_valid=0 that cycle; occupancy=0 next cycle.
  - 0x55 never appears at out_data.
- Async reset mid-operation: pipe full with out_ready=0; pulse rst_n low between clock edges.
  - Required: out_valid and occupancy go 0 before the next edge; no pre-reset word emerges afterward.
- DEPTH=1, DATA_WIDTH=1: alternating out_ready with continuous in_valid.
  - Required: throughput equals the number of out_ready cycles; in_ready follows out_ready when full.
  - Random valid/ready scoreboard over 10k cycles shows zero loss or reorder.
